// File: rtl/avg_pool_arbiter_pkg.sv
// Shared types and helpers for the pooling-unit arbiter.
//   DATA_W_DEF : default pixel/result width
//   WIN_SIZE   : beats per 2x2 window (TL, TR, BL, BR)
//   pool_arb_state_t : arbiter FSM states
//   idx_w(n)   : width of an index able to address n items
package avg_pool_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int WIN_SIZE   = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    FEED = 3'd2,
    WAIT = 3'd3,
    CAPT = 3'd4
  } pool_arb_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/avg_pool_arbiter_if.sv
// Bundle of every non-clock signal of the arbiter.
//   Requester side : flush, req, req_win (in); gnt, busy, rsp_valid, rsp_id, rsp_data (out)
//   Pool-unit side : pu_avg (in); pu_rst, pu_en, pu_din (out)
//   Debug          : state (current FSM state)
// Handshake: gnt is a one-cycle pulse meaning the window of that requester has been
// latched, after which the requester may drop or change req/req_win freely.
// rsp_valid is a one-cycle pulse qualifying rsp_id/rsp_data; there is no backpressure.
// modport slave is the arbiter, modport master is the environment around it.
interface avg_pool_arbiter_if
  import avg_pool_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int ID_W = idx_w(N_REQ);

  logic                             flush;
  logic [N_REQ-1:0]                 req;
  logic [N_REQ*WIN_SIZE*DATA_W-1:0] req_win;
  logic [N_REQ-1:0]                 gnt;
  logic                             busy;
  logic                             rsp_valid;
  logic [ID_W-1:0]                  rsp_id;
  logic [DATA_W-1:0]                rsp_data;
  logic                             pu_rst;
  logic                             pu_en;
  logic [DATA_W-1:0]                pu_din;
  logic [DATA_W-1:0]                pu_avg;
  pool_arb_state_t                  state;

  modport master (
    output flush, req, req_win, pu_avg,
    input  gnt, busy, rsp_valid, rsp_id, rsp_data, pu_rst, pu_en, pu_din, state
  );

  modport slave (
    input  flush, req, req_win, pu_avg,
    output gnt, busy, rsp_valid, rsp_id, rsp_data, pu_rst, pu_en, pu_din, state
  );

endinterface

// File: rtl/avg_pool_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request bits
//   ptr    : highest-priority index this round
//   onehot : one-hot of the winner (zero when nothing requested)
//   idx    : index of the winner (zero when nothing requested)
//   any    : at least one request present
module avg_pool_arbiter_rr_pick
  import avg_pool_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int cand;

  // Walk from the farthest candidate back to ptr so the nearest set bit
  // (in wrapped order starting at ptr) is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (req[cand]) begin
        idx = cand[ID_W-1:0];
        any = 1'b1;
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/avg_pool_arbiter.sv
// Shares one avg_pool_unit between N_REQ requesters. Each granted requester's
// 2x2 window is latched, streamed into the unit one pixel per cycle, and the
// unit's average is returned tagged with the requester id.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : avg_pool_arbiter_if.slave (requester side and pool-unit side)
// Parameters: N_REQ (2..8), DATA_W, LAT (1..15) cycles waited after the last beat.
module avg_pool_arbiter
  import avg_pool_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LAT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  avg_pool_arbiter_if.slave  bus
);

  localparam int        ID_W      = idx_w(N_REQ);
  localparam int        WIN_W     = WIN_SIZE * DATA_W;
  localparam logic [3:0] WAIT_LAST = 4'(LAT - 1);

  pool_arb_state_t   state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [WIN_W-1:0]  win_q;
  logic [1:0]        beat_q;
  logic [3:0]        wait_q;

  logic [N_REQ-1:0]  gnt_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              pu_rst_q;
  logic              pu_en_q;
  logic [DATA_W-1:0] pu_din_q;

  logic [N_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [WIN_W-1:0]  pick_win;
  logic [ID_W-1:0]   ptr_next;

  avg_pool_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign pick_win = bus.req_win[int'(pick_idx)*WIN_W +: WIN_W];
  assign ptr_next = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      win_q       <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      pu_rst_q    <= 1'b0;
      pu_en_q     <= 1'b0;
      pu_din_q    <= '0;
    end else if (bus.flush) begin
      // Abort: drop back to IDLE silently; ptr keeps its post-grant value.
      state_q     <= IDLE;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      pu_rst_q    <= 1'b0;
      pu_en_q     <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          pu_rst_q <= 1'b0;
          pu_en_q  <= 1'b0;
          // The IDLE cycle right after CAPT carries the rsp_valid pulse;
          // arbitration waits for it to retire so a response and the next
          // grant never overlap and each window takes LAT+8 cycles.
          if (pick_any && !rsp_valid_q) begin
            gnt_q   <= pick_onehot;
            id_q    <= pick_idx;
            win_q   <= pick_win;
            ptr_q   <= ptr_next;
            busy_q  <= 1'b1;
            state_q <= CLR;
          end
        end
        CLR: begin
          pu_rst_q <= 1'b1;
          pu_en_q  <= 1'b0;
          beat_q   <= '0;
          state_q  <= FEED;
        end
        FEED: begin
          pu_rst_q <= 1'b0;
          pu_en_q  <= 1'b1;
          pu_din_q <= win_q[int'(beat_q)*DATA_W +: DATA_W];
          beat_q   <= beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            wait_q  <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          pu_en_q <= 1'b0;
          if (wait_q == WAIT_LAST) state_q <= CAPT;
          else                     wait_q  <= wait_q + 4'd1;
        end
        CAPT: begin
          rsp_data_q  <= bus.pu_avg;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.pu_rst    = pu_rst_q;
  assign bus.pu_en     = pu_en_q;
  assign bus.pu_din    = pu_din_q;
  assign bus.state     = state_q;

endmodule
